pulp_conf_regs: RTL and testbench
=================================

Name: pulp_conf_regs

Overview:
- APB register file upstream of cluster_control.
- Captures the ESP-side accelerator configuration: four config words and four target addresses.
- Start command emits a one-cycle conf_done pulse, then tracks the run until cluster_control reports acc_done.
- Exposes status, a saturating run-cycle counter and a level interrupt to the host.

Parameters:
ADDR_W, 8, APB byte-address width; only bits [5:2] are decoded, bits [1:0] are ignored.
N_TGT, 4, number of config/target pairs; fixed at 4 to match the downstream loader.
CYC_W, 32, width of the run-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB write
paddr  in  ADDR_W  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready; tied 1 (zero wait states)
pslverr  out  1  APB error
reg_0..reg_3  out  32 each  config words for the loader
target_addresses  out  32 x [0:3]  loader target addresses
conf_done  out  1  one-cycle start pulse to the loader
acc_done  in  1  completion pulse from the loader
busy  out  1  run in progress
irq  out  1  level interrupt: done & irq_en

Behaviour:
- Reset:
  - State IDLE.
  - All REG/TGT registers = 0; cycles = 0; done = err = irq_en = 0.
  - Outputs conf_done = busy = irq = pslverr = 0; prdata = 0.
- APB:
  - An access completes in the cycle where psel & penable are both high; pready is always 1.
  - Writes commit at that edge.
  - prdata and pslverr are combinational and valid during the access phase.
- Register map (byte offset):
  - 0x00 CMD: W only. Bit0 START, bit1 IRQ_CLR. Reads as 0.
  - 0x04 STATUS: R only. Bit0 busy, bit1 done, bit2 err. Writes are ignored and raise pslverr.
  - 0x08/0x0C/0x10/0x14: REG0..3, R/W.
  - 0x18/0x1C/0x20/0x24: TGT0..3, R/W. Bits [1:0] are forced to 0 (word aligned).
  - 0x28 CYCLES: R only.
  - 0x2C IRQ_EN: bit0, R/W.
  - Any other offset: pslverr = 1, read data 0, write ignored.
- Write protection: a REG/TGT write while busy gives pslverr = 1 and the write is dropped. Reads are always allowed.
- FSM:
  - IDLE:
    - A CMD write with START = 1 moves to ARM.
    - On the same edge: done clears, err clears, cycles clears.
  - ARM:
    - conf_done = 1 for exactly one cycle.
    - busy = 1.
    - Next state is RUN.
  - RUN:
    - busy = 1.
    - cycles increments each cycle and saturates at all-ones.
    - acc_done = 1 moves to IDLE and sets done.
    - acc_done is sampled only in RUN.
  - START while in ARM or RUN: pslverr = 1, command ignored.
- Status and interrupt:
  - acc_done = 1 while in IDLE or ARM is spurious: set err, no state change.
  - IRQ_CLR clears done.
  - If IRQ_CLR and the acc_done that sets done occur in the same cycle, set wins: done = 1.
  - START and IRQ_CLR in the same write: both act; done clears.
- Timing and stability:
  - Latency from the START write edge to conf_done high is 1 cycle.
  - reg_*/target_addresses are driven straight from the flops and are stable from ARM until IDLE, which the loader relies on.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values; no conf_done is emitted.

Decomposition:
- Package pulp_conf_pkg holds:
  - register offset localparams (CMD_OFF .. IRQEN_OFF)
  - STATUS/CMD bit-index constants
  - state_t enum {IDLE, ARM, RUN}
- Single module; no sub-module is warranted. The APB decode is a small combinational case.

Test Plan:
- Program and start:
  - Stimulus: write REG0..3 = 0x11,0x22,0x33,0x44; TGT0..3 = 0x1000_0000 + 4i; write CMD = 0x1.
  - Response: conf_done high exactly 1 cycle, the cycle after the write; busy = 1; outputs match the programmed values.
- Completion:
  - Stimulus: hold RUN 100 cycles, pulse acc_done; IRQ_EN = 1.
  - Response: STATUS = 0x2; CYCLES = 100 ±1 per the defined count start; irq = 1; writing CMD = 0x2 drops irq the next cycle.
- Protection:
  - Stimulus: during RUN, write REG2 = 0xDEAD and CMD = 0x1.
  - Response: both give pslverr = 1; REG2 still 0x33; no second conf_done.
- Spurious and decode errors:
  - Stimulus: acc_done in IDLE.
  - Response: STATUS.err = 1, state IDLE.
  - Stimulus: read 0x30.
  - Response: pslverr = 1, prdata = 0.
- Collision:
  - Stimulus: IRQ_CLR write in the same cycle as acc_done.
  - Response: done = 1, irq stays asserted.
- Reset mid-run:
  - Stimulus: assert rst during RUN.
  - Response: busy = 0, all REG/TGT = 0, CYCLES = 0, no conf_done afterwards.

Source files
------------

// File: rtl/pulp_conf_pkg.sv
// rtl/pulp_conf_pkg.sv - register map, bit indices and FSM states for pulp_conf_regs
package pulp_conf_pkg;

  localparam logic [5:0] CMD_OFF    = 6'h00;
  localparam logic [5:0] STATUS_OFF = 6'h04;
  localparam logic [5:0] REG0_OFF   = 6'h08;
  localparam logic [5:0] REG1_OFF   = 6'h0C;
  localparam logic [5:0] REG2_OFF   = 6'h10;
  localparam logic [5:0] REG3_OFF   = 6'h14;
  localparam logic [5:0] TGT0_OFF   = 6'h18;
  localparam logic [5:0] TGT1_OFF   = 6'h1C;
  localparam logic [5:0] TGT2_OFF   = 6'h20;
  localparam logic [5:0] TGT3_OFF   = 6'h24;
  localparam logic [5:0] CYCLES_OFF = 6'h28;
  localparam logic [5:0] IRQEN_OFF  = 6'h2C;

  localparam int CMD_START_BIT   = 0;
  localparam int CMD_IRQ_CLR_BIT = 1;
  localparam int ST_BUSY_BIT     = 0;
  localparam int ST_DONE_BIT     = 1;
  localparam int ST_ERR_BIT      = 2;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

endpackage

// File: rtl/pulp_conf_regs.sv
// rtl/pulp_conf_regs.sv - APB config/target register file with start/run tracking for cluster_control
module pulp_conf_regs
  import pulp_conf_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int N_TGT  = 4,
  parameter int CYC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0]       reg_0,
  output logic [31:0]       reg_1,
  output logic [31:0]       reg_2,
  output logic [31:0]       reg_3,
  output logic [31:0]       target_addresses [0:N_TGT-1],
  output logic              conf_done,
  input  logic              acc_done,
  output logic              busy,
  output logic              irq
);

  state_t            state;
  logic [31:0]       cfg [0:3];
  logic [CYC_W-1:0]  cycles;
  logic              done, err, irq_en;

  logic [5:0]  off;
  logic [3:0]  word;
  logic [1:0]  cfg_idx, tgt_idx;
  logic        is_cfg, is_tgt, bad_off;
  logic [31:0] rdata;
  logic        access, wr, cmd_wr, start_req, cmd_rej, start_go, clr_go, prot;
  logic        unused_paddr;

  assign word         = paddr[5:2];
  assign off          = {word, 2'b00};
  assign cfg_idx      = 2'(word - 4'd2);
  assign tgt_idx      = 2'(word - 4'd6);
  assign unused_paddr = ^{paddr[ADDR_W-1:6], paddr[1:0]};

  always_comb begin
    is_cfg  = 1'b0;
    is_tgt  = 1'b0;
    bad_off = 1'b0;
    rdata   = '0;
    case (off)
      CMD_OFF:    rdata = '0;
      STATUS_OFF: begin
        rdata[ST_BUSY_BIT] = busy;
        rdata[ST_DONE_BIT] = done;
        rdata[ST_ERR_BIT]  = err;
      end
      REG0_OFF, REG1_OFF, REG2_OFF, REG3_OFF: begin
        is_cfg = 1'b1;
        rdata  = cfg[cfg_idx];
      end
      TGT0_OFF, TGT1_OFF, TGT2_OFF, TGT3_OFF: begin
        is_tgt = 1'b1;
        rdata  = target_addresses[tgt_idx];
      end
      CYCLES_OFF: rdata = 32'(cycles);
      IRQEN_OFF:  rdata = {31'b0, irq_en};
      default:    bad_off = 1'b1;
    endcase
  end

  assign access    = psel & penable;
  assign wr        = access & pwrite;
  assign cmd_wr    = wr & (off == CMD_OFF);
  assign start_req = cmd_wr & pwdata[CMD_START_BIT];
  // A rejected START discards the whole command word, IRQ_CLR included.
  assign cmd_rej   = start_req & busy;
  assign start_go  = start_req & ~busy;
  assign clr_go    = cmd_wr & pwdata[CMD_IRQ_CLR_BIT] & ~cmd_rej;
  assign prot      = wr & (is_cfg | is_tgt) & busy;

  assign pready    = 1'b1;
  assign pslverr   = access & (bad_off | (pwrite & (off == STATUS_OFF)) | prot | cmd_rej);
  assign prdata    = (access & ~pwrite) ? rdata : '0;

  assign busy      = (state != IDLE);
  assign conf_done = (state == ARM);
  assign irq       = done & irq_en;
  assign reg_0     = cfg[0];
  assign reg_1     = cfg[1];
  assign reg_2     = cfg[2];
  assign reg_3     = cfg[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cycles <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      irq_en <= 1'b0;
      for (int i = 0; i < 4; i++) cfg[i] <= '0;
      for (int i = 0; i < N_TGT; i++) target_addresses[i] <= '0;
    end else begin
      case (state)
        IDLE:    if (start_go) state <= ARM;
        ARM:     state <= RUN;
        RUN:     if (acc_done) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (start_go) cycles <= '0;
      else if (state == RUN && cycles != '1) cycles <= cycles + 1'b1;

      // Completion set has priority over a coincident IRQ_CLR.
      if (state == RUN && acc_done) done <= 1'b1;
      else if (start_go || clr_go) done <= 1'b0;

      if (state != RUN && acc_done) err <= 1'b1;
      else if (start_go) err <= 1'b0;

      if (wr && off == IRQEN_OFF) irq_en <= pwdata[0];
      if (wr && is_cfg && !busy) cfg[cfg_idx] <= pwdata;
      if (wr && is_tgt && !busy) target_addresses[tgt_idx] <= {pwdata[31:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_pulp_conf_regs.sv
// tb/tb_pulp_conf_regs.sv - self-checking bench for pulp_conf_regs
module tb_pulp_conf_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite, acc_done;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, conf_done, busy, irq;
  logic [31:0] reg_0, reg_1, reg_2, reg_3;
  logic [31:0] target_addresses [0:3];

  int n_cmp = 0;
  int n_bad = 0;
  int n_conf = 0;

  pulp_conf_regs #(.ADDR_W(8), .N_TGT(4), .CYC_W(32)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3),
    .target_addresses(target_addresses), .conf_done(conf_done),
    .acc_done(acc_done), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 arming, 2 running.
  int          m_phase;
  logic [31:0] m_reg [4];
  logic [31:0] m_tgt [4];
  logic [31:0] m_cyc;
  bit          m_done, m_err, m_ien;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int w = int'(a[5:2]);
    if (w == 1) return {29'b0, m_err, m_done, m_phase != 0};
    if (w >= 2 && w <= 5) return m_reg[w-2];
    if (w >= 6 && w <= 9) return m_tgt[w-6];
    if (w == 10) return m_cyc;
    if (w == 11) return {31'b0, m_ien};
    return 32'h0;
  endfunction

  function automatic bit m_perr(input logic [7:0] a, input bit w, input logic [31:0] d);
    int wd = int'(a[5:2]);
    bit running = (m_phase != 0);
    if (wd > 11) return 1'b1;
    if (!w) return 1'b0;
    if (wd == 1) return 1'b1;
    if (wd >= 2 && wd <= 9) return running;
    if (wd == 0) return d[0] && running;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit wr, running, start;
    int wd;
    if (rst) begin
      m_phase = 0; m_cyc = 0; m_done = 0; m_err = 0; m_ien = 0;
      for (int i = 0; i < 4; i++) begin m_reg[i] = 0; m_tgt[i] = 0; end
    end else begin
      wr      = psel && penable && pwrite;
      wd      = int'(paddr[5:2]);
      running = (m_phase != 0);
      start   = wr && wd == 0 && pwdata[0] && !running;
      if (m_phase == 2 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (start) begin m_cyc = 0; m_done = 0; m_err = 0; end
      if (wr && wd == 0 && pwdata[1] && !(pwdata[0] && running)) m_done = 0;
      if (acc_done) begin
        if (m_phase == 2) m_done = 1; else m_err = 1;
      end
      if (wr && wd == 11) m_ien = pwdata[0];
      if (wr && !running && wd >= 2 && wd <= 5) m_reg[wd-2] = pwdata;
      if (wr && !running && wd >= 6 && wd <= 9) m_tgt[wd-6] = {pwdata[31:2], 2'b00};
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && acc_done) m_phase = 0;
      else if (start) m_phase = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    #1;
    chk("busy", busy, m_phase != 0);
    chk("conf_done", conf_done, m_phase == 1);
    chk("irq", irq, m_done && m_ien);
    chk("pready", pready, 1);
    chk("reg_0", reg_0, m_reg[0]);
    chk("reg_1", reg_1, m_reg[1]);
    chk("reg_2", reg_2, m_reg[2]);
    chk("reg_3", reg_3, m_reg[3]);
    for (int i = 0; i < 4; i++) chk("tgt", target_addresses[i], m_tgt[i]);
    if (psel && penable) begin
      chk("pslverr", pslverr, m_perr(paddr, pwrite, pwdata));
      if (!pwrite) chk("prdata", prdata, m_read(paddr));
    end else begin
      chk("pslverr_idle", pslverr, 0);
      chk("prdata_idle", prdata, 0);
    end
  end

  always @(negedge clk) begin
    #1;
    if (conf_done === 1'b1) n_conf++;
  end

  task automatic apb(input logic [7:0] a, input bit w, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1;
    #1;
    rd = prdata; err = pslverr;
    @(negedge clk);
    psel = 0; penable = 0; pwrite = 0;
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; acc_done = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    apb(8'h2C, 1, 32'h1, rd, e);
    for (int i = 0; i < 4; i++) apb(8'(8 + 4 * i), 1, 32'h11 * (i + 1), rd, e);
    apb(8'h1C, 1, 32'h1000_0007, rd, e);
    apb(8'h1C, 0, 0, rd, e);
    chk("tgt_align", rd, 32'h1000_0004);
    for (int i = 0; i < 4; i++) apb(8'(8'h18 + 4 * i), 1, 32'h1000_0000 + 4 * i, rd, e);

    apb(8'h00, 1, 32'h1, rd, e);
    #1;
    chk("conf_done_lat", conf_done, 1);
    chk("reg_2_lit", reg_2, 32'h33);
    chk("tgt3_lit", target_addresses[3], 32'h1000_000C);
    repeat (100) @(negedge clk);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    apb(8'h04, 0, 0, rd, e);
    chk("status_done", rd, 32'h2);
    apb(8'h28, 0, 0, rd, e);
    chk("cycles_100", rd, 32'd100);
    chk("irq_set", irq, 1);
    apb(8'h00, 1, 32'h2, rd, e);
    #1;
    chk("irq_clr", irq, 0);
    chk("one_conf", n_conf, 1);

    apb(8'h00, 1, 32'h1, rd, e);
    repeat (5) @(negedge clk);
    apb(8'h10, 1, 32'hDEAD, rd, e);
    chk("prot_err", e, 1);
    apb(8'h10, 0, 0, rd, e);
    chk("reg2_kept", rd, 32'h33);
    apb(8'h00, 1, 32'h1, rd, e);
    chk("restart_err", e, 1);
    repeat (3) @(negedge clk);
    chk("two_conf", n_conf, 2);

    fork
      apb(8'h00, 1, 32'h2, rd, e);
      begin
        @(negedge clk); acc_done = 1;
        @(negedge clk); acc_done = 0;
      end
    join
    apb(8'h04, 0, 0, rd, e);
    chk("collide_done", rd, 32'h2);
    chk("collide_irq", irq, 1);

    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    apb(8'h04, 0, 0, rd, e);
    chk("spurious_err", rd, 32'h6);
    chk("spurious_idle", busy, 0);

    apb(8'h30, 0, 0, rd, e);
    chk("bad_off_err", e, 1);
    chk("bad_off_data", rd, 0);

    apb(8'h00, 1, 32'h1, rd, e);
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_reg0", reg_0, 0);
    chk("rst_tgt0", target_addresses[0], 0);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    apb(8'h28, 0, 0, rd, e);
    chk("rst_cycles", rd, 0);
    chk("rst_no_conf", n_conf, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
